// File: rtl/bias_stream_buffer.sv
// Loadable bias/weight row store streaming bursts of packed rows; first row 1 cycle after start.
// Output held stable while w_valid && !w_ready; one row per cycle when the consumer is ready.
module bias_stream_buffer #(
  parameter int D_WL      = 24,
  parameter int UNITS_NUM = 5,
  parameter int DEPTH     = 6,
  parameter int ADDR_W    = 8,
  parameter int LANE_W    = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ld_valid,
  input  logic [ADDR_W-1:0]         ld_addr,
  input  logic [LANE_W-1:0]         ld_lane,
  input  logic [D_WL-1:0]           ld_data,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         start_addr,
  input  logic [ADDR_W-1:0]         burst_len,
  output logic [UNITS_NUM*D_WL-1:0] w_o,
  output logic                      w_valid,
  input  logic                      w_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int ROW_W = UNITS_NUM * D_WL;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ROW_W-1:0]  rows [DEPTH];
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] ptr_nxt;
  logic [ROW_W-1:0]  start_row;
  logic [ROW_W-1:0]  next_row;
  logic              start_ok;
  logic              start_bad;
  logic              ld_ok;
  logic              ld_bad;
  logic              hs;
  logic              last;

  assign start_ok  = (state == S_IDLE) && start && (int'(start_addr) < DEPTH);
  assign start_bad = (state == S_IDLE) && start && (int'(start_addr) >= DEPTH);
  assign ld_ok     = ld_valid && (int'(ld_addr) < DEPTH) && (int'(ld_lane) < UNITS_NUM);
  assign ld_bad    = ld_valid && !ld_ok;
  assign hs        = (state == S_RUN) && w_valid && w_ready;
  assign last      = (cnt == ADDR_W'(1));
  assign ptr_nxt   = (int'(ptr) == DEPTH - 1) ? '0 : ptr + ADDR_W'(1);

  // Fetch muxes read the registered rows, so a same-edge load is not seen (read-before-write).
  always_comb begin
    start_row = '0;
    next_row  = '0;
    for (int r = 0; r < DEPTH; r++) begin
      if (start_addr == ADDR_W'(r)) start_row = rows[r];
      if (ptr_nxt == ADDR_W'(r))    next_row  = rows[r];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (start_ok) state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (hs && last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) rows[r] <= '0;
      ptr     <= '0;
      cnt     <= '0;
      w_o     <= '0;
      w_valid <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (ld_ok) begin
        for (int r = 0; r < DEPTH; r++) begin
          for (int k = 0; k < UNITS_NUM; k++) begin
            if (ld_addr == ADDR_W'(r) && ld_lane == LANE_W'(k))
              rows[r][k*D_WL +: D_WL] <= ld_data;
          end
        end
      end

      if (start_ok) begin
        ptr     <= start_addr;
        cnt     <= (burst_len == '0) ? ADDR_W'(1) : burst_len;
        w_o     <= start_row;
        w_valid <= 1'b1;
        err     <= 1'b0;
      end else if (hs) begin
        cnt <= cnt - ADDR_W'(1);
        if (last) begin
          w_valid <= 1'b0;
        end else begin
          ptr <= ptr_nxt;
          w_o <= next_row;
        end
      end

      // An illegal access in the same cycle as a legal start still flags.
      if (start_bad || ld_bad) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bias_stream_buffer.sv
// Randomized scoreboard bench for bias_stream_buffer with a row-array reference model.
module tb_bias_stream_buffer;
  localparam int D_WL = 24, UNITS_NUM = 5, DEPTH = 6, ADDR_W = 8, LANE_W = 3;
  localparam int ROW_W = UNITS_NUM * D_WL;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ld_valid = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [LANE_W-1:0] ld_lane = '0;
  logic [D_WL-1:0]   ld_data = '0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] burst_len = '0;
  logic [ROW_W-1:0]  w_o;
  logic              w_valid;
  logic              w_ready = 1'b0;
  logic              busy;
  logic              done;
  logic              err;

  bias_stream_buffer #(
    .D_WL(D_WL), .UNITS_NUM(UNITS_NUM), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LANE_W(LANE_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_lane(ld_lane),
    .ld_data(ld_data), .start(start), .start_addr(start_addr), .burst_len(burst_len),
    .w_o(w_o), .w_valid(w_valid), .w_ready(w_ready), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [D_WL-1:0]  mem [DEPTH][UNITS_NUM];
  logic [ROW_W-1:0] exp_q [$];

  task automatic check_row(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] row_of(input int a);
    logic [ROW_W-1:0] v;
    v = '0;
    for (int k = 0; k < UNITS_NUM; k++) v[k*D_WL +: D_WL] = mem[a][k];
    return v;
  endfunction

  // Monitor: pops one expected row per handshake, and checks output stability across stalls.
  logic [ROW_W-1:0] held;
  bit               stalled = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 0;
    end else begin
      if (done) done_cnt++;
      if (stalled) begin
        check_bit("stall_valid_held", w_valid, 1'b1);
        check_row("stall_row_held", w_o, held);
      end
      if (w_valid && w_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_row: got %h expected none", w_o);
        end else begin
          check_row("stream_row", w_o, exp_q.pop_front());
        end
      end
      stalled = w_valid && !w_ready;
      held    = w_o;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input int l, input logic [D_WL-1:0] d);
    ld_valid = 1'b1;
    ld_addr  = ADDR_W'(a);
    ld_lane  = LANE_W'(l);
    ld_data  = d;
    cycle();
    ld_valid = 1'b0;
    if (a < DEPTH && l < UNITS_NUM) mem[a][l] = d;
  endtask

  function automatic logic ready_pick(input int mode, input int i);
    logic [4:0] pat;
    pat = 5'b11001;
    if (mode == 0) return 1'b1;
    if (mode == 1) return 1'($urandom_range(0, 1));
    return pat[i % 5];
  endfunction

  // Expected rows are queued from the model at start time; any load driven in the start
  // cycle is applied to the model by the caller afterwards.
  task automatic do_burst(input int a, input int len, input int mode,
                          input bit chk_first, input logic [ROW_W-1:0] first_exp);
    int n;
    int d0;
    int i;
    bit seen;
    n    = (len == 0) ? 1 : len;
    d0   = done_cnt;
    i    = 0;
    seen = 0;
    for (int k = 0; k < n; k++) exp_q.push_back(row_of((a + k) % DEPTH));
    start      = 1'b1;
    start_addr = ADDR_W'(a);
    burst_len  = ADDR_W'(len);
    w_ready    = 1'b0;
    cycle();
    start    = 1'b0;
    ld_valid = 1'b0;
    check_bit("valid_after_start", w_valid, 1'b1);
    check_bit("busy_run", busy, 1'b1);
    check_bit("err_cleared_by_start", err, 1'b0);
    if (chk_first) check_row("first_row", w_o, first_exp);
    for (int c = 0; c < 300 && !seen; c++) begin
      w_ready = ready_pick(mode, i);
      i++;
      cycle();
      if (done) begin
        seen = 1;
        check_bit("busy_in_done", busy, 1'b0);
        check_bit("valid_in_done", w_valid, 1'b0);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL burst_timeout: got no done expected done within 300 cycles");
    end
    w_ready = 1'b0;
    cycle();
    check_int("done_pulses", done_cnt - d0, 1);
    check_int("rows_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ROW_W-1:0] t1;
    int ra;
    int rl;
    for (int r = 0; r < DEPTH; r++)
      for (int k = 0; k < UNITS_NUM; k++) mem[r][k] = '0;

    repeat (2) cycle();
    check_row("reset_w_o", w_o, '0);
    check_bit("reset_valid", w_valid, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_done", done, 1'b0);
    check_bit("reset_err", err, 1'b0);
    rst_n = 1'b1;
    cycle();

    // Single-row burst with known packed value.
    load(3, 0, 24'h0038ea);
    load(3, 1, 24'h004863);
    load(3, 2, 24'h005a0e);
    load(3, 3, 24'h003bf4);
    load(3, 4, 24'h005cec);
    t1 = 120'h005cec_003bf4_005a0e_004863_0038ea;
    do_burst(3, 1, 0, 1, t1);

    // Distinct rows, wrapping burst, then the same burst under a stall pattern.
    for (int r = 0; r < DEPTH; r++)
      for (int k = 0; k < UNITS_NUM; k++) load(r, k, D_WL'((r << 16) | (k << 8) | $urandom_range(0, 255)));
    do_burst(4, 4, 0, 0, '0);
    do_burst(4, 4, 2, 0, '0);

    // Illegal start and loads.
    start = 1'b1; start_addr = ADDR_W'(6); burst_len = ADDR_W'(1);
    cycle();
    start = 1'b0;
    cycle();
    check_bit("bad_start_err", err, 1'b1);
    check_bit("bad_start_busy", busy, 1'b0);
    check_bit("bad_start_valid", w_valid, 1'b0);
    do_burst(0, 1, 0, 0, '0);
    load(0, 5, 24'habcdef);
    check_bit("bad_lane_err", err, 1'b1);
    load(6, 0, 24'h123456);
    check_bit("bad_addr_err", err, 1'b1);
    do_burst(0, DEPTH, 1, 0, '0);

    // Same-cycle load to the row being fetched: old row streamed, new row on re-burst.
    ld_valid = 1'b1; ld_addr = ADDR_W'(2); ld_lane = '0; ld_data = 24'h7e57ab;
    do_burst(2, 1, 0, 0, '0);
    mem[2][0] = 24'h7e57ab;
    do_burst(2, 1, 0, 0, '0);

    // Randomized loads and bursts, burst_len 0 included.
    for (int it = 0; it < 12; it++) begin
      for (int j = 0; j < 4; j++) begin
        ra = ($urandom_range(0, 7) == 0) ? DEPTH : $urandom_range(0, DEPTH - 1);
        rl = $urandom_range(0, UNITS_NUM - 1);
        load(ra, rl, D_WL'($urandom));
      end
      do_burst($urandom_range(0, DEPTH - 1), $urandom_range(0, 9), 1, 0, '0);
    end

    // Mid-burst: ignored start, illegal load, then async reset abort.
    begin
      int d0;
      d0 = done_cnt;
      start = 1'b1; start_addr = ADDR_W'(1); burst_len = ADDR_W'(5); w_ready = 1'b0;
      cycle();
      start = 1'b0;
      cycle();
      start = 1'b1; start_addr = ADDR_W'(4); burst_len = ADDR_W'(2);
      cycle();
      start = 1'b0;
      check_row("busy_start_ignored", w_o, row_of(1));
      load(9, 0, 24'h000001);
      check_bit("run_bad_load_err", err, 1'b1);
      #3 rst_n = 1'b0;
      #1;
      check_bit("arst_valid", w_valid, 1'b0);
      check_bit("arst_busy", busy, 1'b0);
      check_bit("arst_err", err, 1'b0);
      check_bit("arst_done", done, 1'b0);
      check_row("arst_w_o", w_o, '0);
      exp_q.delete();
      for (int r = 0; r < DEPTH; r++)
        for (int k = 0; k < UNITS_NUM; k++) mem[r][k] = '0;
      cycle();
      cycle();
      rst_n = 1'b1;
      cycle();
      check_int("no_done_on_abort", done_cnt - d0, 0);
    end
    do_burst(0, DEPTH, 0, 0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
